// File: rtl/db_fifo_param_if.sv
// Handshake bundle between the USB data-buffer FIFO and its producer/consumers.
// master = producer/consumer side, slave = the FIFO itself.
interface db_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
);
    localparam int AW = $clog2(DEPTH);

    logic              clear;
    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              get_tx_data;
    logic              get_rx_data;
    logic [DATA_W-1:0] tx_packet_data;
    logic              tx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic [AW:0]       buff_occ;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              overflow;
    logic              underflow;

    modport master (
        output clear, flush, wr_en, wr_data, get_tx_data, get_rx_data,
        input  tx_packet_data, tx_valid, rx_data, rx_valid,
        input  buff_occ, full, empty, almost_full, overflow, underflow
    );

    modport slave (
        input  clear, flush, wr_en, wr_data, get_tx_data, get_rx_data,
        output tx_packet_data, tx_valid, rx_data, rx_valid,
        output buff_occ, full, empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/db_fifo_param.sv
// Parametrised endpoint data-buffer FIFO with TX-priority dual read ports.
// Define DB_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module db_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int AFULL_LVL = DEPTH - 8
) (
    input logic             clk,
    input logic             rst,
    db_fifo_param_if.slave  bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_OCC = (AW+1)'(AFULL_LVL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW:0]       wrPtr_q, wrPtr_d;
    logic [AW:0]       rdPtr_q, rdPtr_d;
    logic [DATA_W-1:0] txData_q, txData_d;
    logic [DATA_W-1:0] rxData_q, rxData_d;
    logic              txValid_q, txValid_d;
    logic              rxValid_q, rxValid_d;

    logic [AW:0]       occ;
    logic              isFull;
    logic              isEmpty;
    logic              clrReq;
    logic              popTx;
    logic              popRx;
    logic              popAny;
    logic              pushOk;
    logic [DATA_W-1:0] headWord;

    // The wrap bit makes the pointer difference the true occupancy 0..DEPTH.
    assign occ      = wrPtr_q - rdPtr_q;
    assign isFull   = (occ == FULL_OCC);
    assign isEmpty  = (occ == '0);
    assign clrReq   = bus.clear | bus.flush;
    assign popTx    = bus.get_tx_data & ~isEmpty;
    assign popRx    = bus.get_rx_data & ~bus.get_tx_data & ~isEmpty;
    assign popAny   = popTx | popRx;
    assign pushOk   = bus.wr_en & (~isFull | popAny);
    assign headWord = mem[rdPtr_q[AW-1:0]];

    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        txData_d  = txData_q;
        rxData_d  = rxData_q;
        txValid_d = 1'b0;
        rxValid_d = 1'b0;
        if (clrReq) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (popTx) begin
                txData_d  = headWord;
                txValid_d = 1'b1;
            end
            if (popRx) begin
                rxData_d  = headWord;
                rxValid_d = 1'b1;
            end
            if (popAny) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            if (pushOk) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            txData_q  <= '0;
            rxData_q  <= '0;
            txValid_q <= 1'b0;
            rxValid_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            txData_q  <= txData_d;
            rxData_q  <= rxData_d;
            txValid_q <= txValid_d;
            rxValid_q <= rxValid_d;
        end
    end

    // Storage has no reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (pushOk && !clrReq && !rst) begin
            mem[wrPtr_q[AW-1:0]] <= bus.wr_data;
        end
    end

`ifdef DB_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;
    logic ovfEvent;
    logic udfEvent;

    assign ovfEvent = bus.wr_en & isFull & ~popAny;
    assign udfEvent = (bus.get_tx_data | bus.get_rx_data) & isEmpty;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clrReq) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            overflow_d  = overflow_q | ovfEvent;
            underflow_d = underflow_q | udfEvent;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.tx_packet_data = txData_q;
    assign bus.tx_valid       = txValid_q;
    assign bus.rx_data        = rxData_q;
    assign bus.rx_valid       = rxValid_q;
    assign bus.buff_occ       = occ;
    assign bus.full           = isFull;
    assign bus.empty          = isEmpty;
    assign bus.almost_full    = (occ >= AFULL_OCC);
endmodule

// File: tb/tb_db_fifo_param.sv
// Self-checking bench for db_fifo_param: directed scenarios followed by biased
// random traffic, all compared against a queue-based reference model.
module tb_db_fifo_param;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 64;
    localparam int AFULL_LVL = DEPTH - 8;
    localparam int AW        = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;

    db_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    db_fifo_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_LVL(AFULL_LVL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [DATA_W-1:0] modelQ[$];
    logic [DATA_W-1:0] mTxData, mRxData;
    logic              mTxValid, mRxValid, mOvf, mUdf;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                     tag, $time, observed, expected);
        end
    endtask

    task automatic checkAll();
        int occ;
        occ = modelQ.size();
        checkOutput("tx_packet_data", 32'(bus.tx_packet_data), 32'(mTxData));
        checkOutput("tx_valid",       32'(bus.tx_valid),       32'(mTxValid));
        checkOutput("rx_data",        32'(bus.rx_data),        32'(mRxData));
        checkOutput("rx_valid",       32'(bus.rx_valid),       32'(mRxValid));
        checkOutput("buff_occ",       32'(bus.buff_occ),       32'(occ));
        checkOutput("full",           32'(bus.full),           32'(occ == DEPTH));
        checkOutput("empty",          32'(bus.empty),          32'(occ == 0));
        checkOutput("almost_full",    32'(bus.almost_full),    32'(occ >= AFULL_LVL));
        checkOutput("overflow",       32'(bus.overflow),       32'(mOvf));
        checkOutput("underflow",      32'(bus.underflow),      32'(mUdf));
    endtask

    task automatic modelReset();
        modelQ.delete();
        mTxData  = '0;
        mRxData  = '0;
        mTxValid = 1'b0;
        mRxValid = 1'b0;
        mOvf     = 1'b0;
        mUdf     = 1'b0;
    endtask

    // Reference model: one clock edge of FIFO behaviour in queue terms.
    task automatic modelStep(input bit clr, input bit we, input logic [DATA_W-1:0] wd,
                             input bit gtx, input bit grx);
        int  occ;
        bit  takeTx, takeRx, ovfEvt, udfEvt;
        occ = modelQ.size();
        if (clr) begin
            modelQ.delete();
            mTxValid = 1'b0;
            mRxValid = 1'b0;
            mOvf     = 1'b0;
            mUdf     = 1'b0;
        end else begin
            takeTx = gtx && occ > 0;
            takeRx = grx && !gtx && occ > 0;
            ovfEvt = we && occ == DEPTH && !(takeTx || takeRx);
            udfEvt = (gtx || grx) && occ == 0;
            mTxValid = takeTx;
            mRxValid = takeRx;
            if (takeTx) mTxData = modelQ.pop_front();
            if (takeRx) mRxData = modelQ.pop_front();
            if (we && (occ < DEPTH || takeTx || takeRx)) modelQ.push_back(wd);
`ifdef DB_FIFO_ERR_EN
            mOvf = mOvf | ovfEvt;
            mUdf = mUdf | udfEvt;
`else
            if (ovfEvt || udfEvt) begin
                mOvf = 1'b0;
                mUdf = 1'b0;
            end
`endif
        end
    endtask

    task automatic applyStimulus(input bit clr, input bit fl, input bit we,
                                 input logic [DATA_W-1:0] wd, input bit gtx, input bit grx);
        bus.clear       = clr;
        bus.flush       = fl;
        bus.wr_en       = we;
        bus.wr_data     = wd;
        bus.get_tx_data = gtx;
        bus.get_rx_data = grx;
        @(posedge clk);
        #1;
        modelStep(clr || fl, we, wd, gtx, grx);
        checkAll();
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        logic [DATA_W-1:0] seqVals[3];
        int pWr[4];
        int pTx[4];
        int pRx[4];
        seqVals = '{8'h11, 8'h22, 8'h33};
        pWr = '{85, 30, 60, 97};
        pTx = '{15, 70, 35, 5};
        pRx = '{25, 40, 40, 5};

        bus.clear = 0; bus.flush = 0; bus.wr_en = 0; bus.wr_data = '0;
        bus.get_tx_data = 0; bus.get_rx_data = 0;
        modelReset();
        #12;
        checkAll();
        @(negedge clk);
        rst = 1'b0;

        // Basic in-order TX delivery
        foreach (seqVals[i]) applyStimulus(0, 0, 1, seqVals[i], 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, '0, 1, 0);
        idle();

        // Fill to full, then a dropped push
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, 8'(i + 8'h40), 0, 0);
        applyStimulus(0, 0, 1, 8'hAA, 0, 0);

        // Full with simultaneous push and RX pop, then drain via TX
        applyStimulus(0, 0, 1, 8'hBE, 0, 1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, '0, 1, 0);
        applyStimulus(1, 0, 0, '0, 0, 0);

        // TX wins arbitration over RX
        applyStimulus(0, 0, 1, 8'h01, 0, 0);
        applyStimulus(0, 0, 1, 8'h02, 0, 0);
        applyStimulus(0, 0, 0, '0, 1, 1);
        applyStimulus(0, 0, 0, '0, 0, 1);

        // Empty: push and pop together -> no fall-through
        applyStimulus(0, 1, 0, '0, 0, 0);
        applyStimulus(0, 0, 1, 8'h5C, 1, 0);
        applyStimulus(0, 0, 0, '0, 1, 0);

        // Flush wins over simultaneous push and pop
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 8'(8'hC0 + i), 0, 0);
        applyStimulus(0, 1, 1, 8'hEE, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 8'(8'hD0 + i), 0, 0);
        applyStimulus(0, 0, 1, 8'hD8, 1, 0);

        // Asynchronous reset mid-transfer
        bus.wr_en = 1; bus.wr_data = 8'h77; bus.get_tx_data = 1;
        #3;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        #1;
        checkAll();
        bus.wr_en = 0; bus.get_tx_data = 0;
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Biased random traffic
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 600; n++) begin
                applyStimulus($urandom_range(99) < 1, $urandom_range(99) < 1,
                              $urandom_range(99) < pWr[ph], 8'($urandom),
                              $urandom_range(99) < pTx[ph], $urandom_range(99) < pRx[ph]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
